// File: rtl/motor_pkg.sv
// motor_pkg: shared constants, types and the steering-code decode for motor_drive.
package motor_pkg;

  // Steering codes {side[1:0], severity[1:0]}
  localparam logic [3:0] DIR_PROCEED      = 4'b0000;
  localparam logic [3:0] DIR_VEER_RIGHT   = 4'b1001;
  localparam logic [3:0] DIR_HARD_RIGHT   = 4'b1010;
  localparam logic [3:0] DIR_NINETY_RIGHT = 4'b1011;
  localparam logic [3:0] DIR_VEER_LEFT    = 4'b0101;
  localparam logic [3:0] DIR_HARD_LEFT    = 4'b0110;
  localparam logic [3:0] DIR_NINETY_LEFT  = 4'b0111;
  localparam logic [3:0] DIR_STOP         = 4'b1111;

  localparam logic [7:0] DUTY_FULL  = 8'd255;
  localparam logic [7:0] DUTY_VEER  = 8'd192;
  localparam logic [7:0] DUTY_HARD  = 8'd64;
  localparam logic [7:0] DUTY_PIVOT = 8'd128;

  // H-bridge {in1,in2}
  localparam logic [1:0] BR_FWD   = 2'b10;
  localparam logic [1:0] BR_REV   = 2'b01;
  localparam logic [1:0] BR_COAST = 2'b00;
  localparam logic [1:0] BR_BRAKE = 2'b11;

  typedef enum logic {CH_RUN, CH_DEAD} ch_state_t;

  // pol: 1 = bridge forward, 0 = bridge reverse (absolute, after Direction)
  typedef struct packed {
    logic [7:0] duty;
    logic       pol;
    logic       brake;
  } wheel_tgt_t;

  typedef struct packed {
    wheel_tgt_t left;
    wheel_tgt_t right;
  } drive_tgt_t;

  // Decode a steering code into per-wheel targets; travel BACKWARDS inverts both wheels.
  function automatic drive_tgt_t decode_dir(input logic [3:0] code, input logic fwd);
    drive_tgt_t t;
    t.left  = '{duty: 8'd0, pol: 1'b1, brake: 1'b0};
    t.right = '{duty: 8'd0, pol: 1'b1, brake: 1'b0};
    case (code)
      DIR_PROCEED:      begin t.left.duty = DUTY_FULL;  t.right.duty = DUTY_FULL;  end
      DIR_VEER_RIGHT:   begin t.left.duty = DUTY_FULL;  t.right.duty = DUTY_VEER;  end
      DIR_HARD_RIGHT:   begin t.left.duty = DUTY_FULL;  t.right.duty = DUTY_HARD;  end
      DIR_NINETY_RIGHT: begin t.left.duty = DUTY_PIVOT; t.right.duty = DUTY_PIVOT; t.right.pol = 1'b0; end
      DIR_VEER_LEFT:    begin t.left.duty = DUTY_VEER;  t.right.duty = DUTY_FULL;  end
      DIR_HARD_LEFT:    begin t.left.duty = DUTY_HARD;  t.right.duty = DUTY_FULL;  end
      DIR_NINETY_LEFT:  begin t.left.duty = DUTY_PIVOT; t.right.duty = DUTY_PIVOT; t.left.pol = 1'b0; end
      default:          begin t.left.brake = 1'b1; t.right.brake = 1'b1; end
    endcase
    t.left.pol  = t.left.pol  ~^ fwd;
    t.right.pol = t.right.pol ~^ fwd;
    return t;
  endfunction

endpackage

// File: rtl/motor_drive_if.sv
// motor_drive_if: steering inputs, motor pins and debug taps of motor_drive.
// All signals are level-sampled on every clk; there is no valid/ready handshake.
interface motor_drive_if;
  logic [3:0] DIR;
  logic       Direction;
  logic       left_pwm;
  logic [1:0] left_dir;
  logic       right_pwm;
  logic [1:0] right_dir;
  logic       idle;
  // debug taps: PWM period tick, applied duty and channel state (1 = DEAD)
  logic       dbg_tick;
  logic [7:0] dbg_left_applied;
  logic [7:0] dbg_right_applied;
  logic       dbg_left_state;
  logic       dbg_right_state;

  modport master (
    output DIR, Direction,
    input  left_pwm, left_dir, right_pwm, right_dir, idle,
    input  dbg_tick, dbg_left_applied, dbg_right_applied, dbg_left_state, dbg_right_state
  );

  modport slave (
    input  DIR, Direction,
    output left_pwm, left_dir, right_pwm, right_dir, idle,
    output dbg_tick, dbg_left_applied, dbg_right_applied, dbg_left_state, dbg_right_state
  );
endinterface

// File: rtl/motor_channel.sv
// motor_channel: one wheel's duty ramp, reversal dead time, PWM and bridge drive.
// MOTOR_DRIVE_RAMP_EN defined: duty slews by RAMP_STEP per tick; otherwise it jumps.
module motor_channel
  import motor_pkg::*;
#(
  parameter int RAMP_STEP        = 4,
  parameter int DEADTIME_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tgt_duty,
  input  logic       tgt_pol,
  input  logic       tgt_brake,
  input  logic       tick,
  input  logic [7:0] cnt,
  output logic       pwm,
  output logic [1:0] dir,
  output logic       busy,
  output logic [7:0] applied,
  output ch_state_t  state
);

`ifdef MOTOR_DRIVE_RAMP_EN
  localparam logic [7:0] STEP = 8'(RAMP_STEP);
`else
  // a step of 255 covers any difference, so applied lands on the target in one tick
  localparam logic [7:0] STEP = 8'(RAMP_STEP) | 8'hFF;
`endif
  localparam logic [15:0] DT_LAST = 16'(DEADTIME_PERIODS - 1);

  logic        pol;
  logic [15:0] dt_cnt;
  logic        differs;
  logic [7:0]  eff, diff, step_amt, stepped;
  ch_state_t   nxt_state;
  logic [7:0]  nxt_applied;
  logic        nxt_pol;
  logic [15:0] nxt_dt;
  logic [1:0]  nxt_dir;

  // Next-state: ramp toward the effective target, park in DEAD before a reversal.
  always_comb begin
    // a brake target has no polarity of its own, so it never forces a reversal
    differs  = !tgt_brake && (tgt_pol != pol);
    eff      = differs ? 8'd0 : tgt_duty;
    diff     = (applied < eff) ? (eff - applied) : (applied - eff);
    step_amt = (diff < STEP) ? diff : STEP;
    stepped  = (applied < eff) ? (applied + step_amt) : (applied - step_amt);

    nxt_state   = state;
    nxt_applied = applied;
    nxt_pol     = pol;
    nxt_dt      = dt_cnt;
    if (tick) begin
      case (state)
        CH_RUN: begin
          if (applied == 8'd0 && differs) begin
            nxt_state = CH_DEAD;
            nxt_dt    = 16'd0;
          end else begin
            nxt_applied = stepped;
          end
        end
        CH_DEAD: begin
          nxt_applied = 8'd0;
          if (dt_cnt == DT_LAST) begin
            nxt_state = CH_RUN;
            nxt_pol   = tgt_pol;
            nxt_dt    = 16'd0;
          end else begin
            nxt_dt = dt_cnt + 16'd1;
          end
        end
        default: nxt_state = CH_RUN;
      endcase
    end

    if (nxt_state == CH_DEAD)                    nxt_dir = BR_COAST;
    else if (tgt_brake && nxt_applied == 8'd0)   nxt_dir = BR_BRAKE;
    else                                         nxt_dir = nxt_pol ? BR_FWD : BR_REV;
  end

  // Channel FSM state and registered pin outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CH_RUN;
      applied <= 8'd0;
      pol     <= 1'b1;
      dt_cnt  <= 16'd0;
      dir     <= BR_COAST;
      pwm     <= 1'b0;
    end else begin
      state   <= nxt_state;
      applied <= nxt_applied;
      pol     <= nxt_pol;
      dt_cnt  <= nxt_dt;
      dir     <= nxt_dir;
      pwm     <= (cnt < applied);
    end
  end

  assign busy = (state == CH_DEAD) || (applied != 8'd0);

endmodule

// File: rtl/motor_drive.sv
// motor_drive: steering code + travel direction to two wheel PWM/bridge channels.
// MOTOR_DRIVE_RAMP_EN selects slew-limited duty inside motor_channel.
module motor_drive
  import motor_pkg::*;
#(
  parameter int PWM_PRESCALE     = 195,
  parameter int RAMP_STEP        = 4,
  parameter int DEADTIME_PERIODS = 4
) (
  input  logic          clk,
  input  logic          reset,
  motor_drive_if.slave  bus
);

  logic [15:0] pre;
  logic [7:0]  cnt;
  logic        wrap, tick;
  logic [3:0]  dir_q;
  logic        direction_q;
  drive_tgt_t  tgt_q;
  logic        l_busy, r_busy;
  ch_state_t   l_state, r_state;

  assign wrap = (pre == 16'(PWM_PRESCALE - 1));
  assign tick = wrap && (cnt == 8'hFF);

  // Timebase: prescaler paces the 8-bit slot counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= 16'd0;
      cnt <= 8'd0;
    end else if (wrap) begin
      pre <= 16'd0;
      cnt <= cnt + 8'd1;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // Register the raw inputs, then the decoded per-wheel targets.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q       <= DIR_STOP;
      direction_q <= 1'b1;
      tgt_q       <= decode_dir(DIR_STOP, 1'b1);
    end else begin
      dir_q       <= bus.DIR;
      direction_q <= bus.Direction;
      tgt_q       <= decode_dir(dir_q, direction_q);
    end
  end

  // Idle once both wheels are at zero duty and out of dead time.
  always_ff @(posedge clk) begin
    if (reset) bus.idle <= 1'b0;
    else       bus.idle <= !l_busy && !r_busy;
  end

  motor_channel #(.RAMP_STEP(RAMP_STEP), .DEADTIME_PERIODS(DEADTIME_PERIODS)) u_left (
    .clk(clk), .reset(reset),
    .tgt_duty(tgt_q.left.duty), .tgt_pol(tgt_q.left.pol), .tgt_brake(tgt_q.left.brake),
    .tick(tick), .cnt(cnt),
    .pwm(bus.left_pwm), .dir(bus.left_dir), .busy(l_busy),
    .applied(bus.dbg_left_applied), .state(l_state)
  );

  motor_channel #(.RAMP_STEP(RAMP_STEP), .DEADTIME_PERIODS(DEADTIME_PERIODS)) u_right (
    .clk(clk), .reset(reset),
    .tgt_duty(tgt_q.right.duty), .tgt_pol(tgt_q.right.pol), .tgt_brake(tgt_q.right.brake),
    .tick(tick), .cnt(cnt),
    .pwm(bus.right_pwm), .dir(bus.right_dir), .busy(r_busy),
    .applied(bus.dbg_right_applied), .state(r_state)
  );

  assign bus.dbg_tick        = tick;
  assign bus.dbg_left_state  = (l_state == CH_DEAD);
  assign bus.dbg_right_state = (r_state == CH_DEAD);

endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: directed checks of motor_drive with PWM_PRESCALE=1, RAMP_STEP=64, DEADTIME_PERIODS=2.
module tb_motor_drive;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   lh, rh;

  motor_drive_if bus();

  motor_drive #(.PWM_PRESCALE(1), .RAMP_STEP(64), .DEADTIME_PERIODS(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // clock
  always #5 clk = ~clk;

  // Expected per-tick sequences (dir: 2=fwd, 1=rev, 0=coast).
`ifdef MOTOR_DRIVE_RAMP_EN
  localparam int N_UP = 4;
  localparam int N_HARD = 3;
  localparam int N_PIV = 9;
  localparam int N_REV = 11;
  int up_seq[N_UP]     = '{64, 128, 192, 255};
  int hard_seq[N_HARD] = '{191, 127, 64};
  int piv_app[N_PIV]   = '{191, 127, 63, 0, 0, 0, 0, 64, 128};
  int piv_dir[N_PIV]   = '{2, 2, 2, 2, 0, 0, 1, 1, 1};
  int rev_app[N_REV]   = '{191, 127, 63, 0, 0, 0, 0, 64, 128, 192, 255};
  int rev_dir[N_REV]   = '{2, 2, 2, 2, 0, 0, 1, 1, 1, 1, 1};
  int mid_ticks        = 2;
  int mid_app          = 128;
`else
  localparam int N_UP = 1;
  localparam int N_HARD = 1;
  localparam int N_PIV = 5;
  localparam int N_REV = 5;
  int up_seq[N_UP]     = '{255};
  int hard_seq[N_HARD] = '{64};
  int piv_app[N_PIV]   = '{0, 0, 0, 0, 128};
  int piv_dir[N_PIV]   = '{2, 0, 0, 1, 1};
  int rev_app[N_REV]   = '{0, 0, 0, 0, 255};
  int rev_dir[N_REV]   = '{2, 0, 0, 1, 1};
  int mid_ticks        = 1;
  int mid_app          = 255;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next PWM period tick; call at #1 after a clk edge.
  task automatic next_tick();
    int n = 0;
    while (bus.dbg_tick !== 1'b1 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("tick_wait", 32'(n < 600), 32'd1);
    @(posedge clk); #1;
  endtask

  // Count high pwm cycles on each wheel over one full 256-cycle period.
  task automatic count_high(output int l, output int r);
    l = 0;
    r = 0;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      l += int'(bus.left_pwm);
      r += int'(bus.right_pwm);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.DIR = 4'b1111;
    bus.Direction = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_left_pwm", 32'(bus.left_pwm), 0);
    check_eq("rst_right_pwm", 32'(bus.right_pwm), 0);
    check_eq("rst_left_dir", 32'(bus.left_dir), 0);
    check_eq("rst_right_dir", 32'(bus.right_dir), 0);
    check_eq("rst_idle", 32'(bus.idle), 0);
    check_eq("rst_applied", 32'(bus.dbg_left_applied), 0);
    check_eq("rst_state", 32'(bus.dbg_left_state), 0);
    reset = 1'b0;

    // STOP held for three periods: brake, no pwm, idle
    repeat (3) next_tick();
    count_high(lh, rh);
    check_eq("stop_left_high", 32'(lh), 0);
    check_eq("stop_right_high", 32'(rh), 0);
    check_eq("stop_left_dir", 32'(bus.left_dir), 3);
    check_eq("stop_right_dir", 32'(bus.right_dir), 3);
    check_eq("stop_idle", 32'(bus.idle), 1);

    // STOP -> PROCEED
    next_tick();
    bus.DIR = 4'b0000;
    for (int i = 0; i < N_UP; i++) begin
      next_tick();
      check_eq($sformatf("up_left_%0d", i), 32'(bus.dbg_left_applied), 32'(up_seq[i]));
    end
    check_eq("up_right", 32'(bus.dbg_right_applied), 255);
    count_high(lh, rh);
    check_eq("full_left_high", 32'(lh), 255);
    check_eq("full_right_high", 32'(rh), 255);
    check_eq("full_left_dir", 32'(bus.left_dir), 2);
    check_eq("full_idle", 32'(bus.idle), 0);

    // PROCEED -> HARD_RIGHT
    next_tick();
    bus.DIR = 4'b1010;
    for (int i = 0; i < N_HARD; i++) begin
      next_tick();
      check_eq($sformatf("hard_right_%0d", i), 32'(bus.dbg_right_applied), 32'(hard_seq[i]));
      check_eq($sformatf("hard_left_%0d", i), 32'(bus.dbg_left_applied), 255);
    end
    count_high(lh, rh);
    check_eq("hard_right_high", 32'(rh), 64);

    // back to PROCEED, then NINETY_RIGHT pivot
    next_tick();
    bus.DIR = 4'b0000;
    for (int i = 0; i < N_HARD; i++) next_tick();
    check_eq("back_right", 32'(bus.dbg_right_applied), 255);
    bus.DIR = 4'b1011;
    for (int i = 0; i < N_PIV; i++) begin
      next_tick();
      check_eq($sformatf("piv_right_app_%0d", i), 32'(bus.dbg_right_applied), 32'(piv_app[i]));
      check_eq($sformatf("piv_right_dir_%0d", i), 32'(bus.right_dir), 32'(piv_dir[i]));
    end
    check_eq("piv_left_app", 32'(bus.dbg_left_applied), 128);
    check_eq("piv_left_dir", 32'(bus.left_dir), 2);

    // reset pulse mid-ramp
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.DIR = 4'b0000;
    for (int i = 0; i < mid_ticks; i++) next_tick();
    check_eq("mid_applied", 32'(bus.dbg_left_applied), 32'(mid_app));
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_left_pwm", 32'(bus.left_pwm), 0);
    check_eq("midrst_right_pwm", 32'(bus.right_pwm), 0);
    check_eq("midrst_left_dir", 32'(bus.left_dir), 0);
    check_eq("midrst_right_dir", 32'(bus.right_dir), 0);
    check_eq("midrst_left_app", 32'(bus.dbg_left_applied), 0);
    check_eq("midrst_right_app", 32'(bus.dbg_right_applied), 0);
    reset = 1'b0;

    // full speed forwards, then travel reversal
    for (int i = 0; i < N_UP; i++) next_tick();
    check_eq("prerev_left", 32'(bus.dbg_left_applied), 255);
    bus.Direction = 1'b0;
    for (int i = 0; i < N_REV; i++) begin
      next_tick();
      check_eq($sformatf("rev_left_app_%0d", i), 32'(bus.dbg_left_applied), 32'(rev_app[i]));
      check_eq($sformatf("rev_left_dir_%0d", i), 32'(bus.left_dir), 32'(rev_dir[i]));
    end
    check_eq("rev_right_app", 32'(bus.dbg_right_applied), 255);
    check_eq("rev_right_dir", 32'(bus.right_dir), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
